// File: rtl/dm_pkg.sv
// Shared constants and helpers for the multi-port data memory: default widths,
// region bases, write-source priority order and instruction field offsets.
package dm_pkg;

    localparam int DM_DATA_W   = 32;
    localparam int DM_ADDR_W   = 8;
    localparam int DM_NUM_RD   = 2;
    localparam int DM_WB_DELAY = 4;

    localparam logic [7:0] DM_BASE_SHIFT = 8'h20;
    localparam logic [7:0] DM_BASE_WB    = 8'h40;
    localparam logic [7:0] DM_BASE_TX    = 8'h80;

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_LOAD  = 3'd1,
        SRC_SHIFT = 3'd2,
        SRC_TX    = 3'd3,
        SRC_WB    = 3'd4
    } wr_src_e;

    // Rank 0 is the highest-priority write source.
    localparam int      WR_NUM_SRC = 4;
    localparam wr_src_e WR_PRIO [WR_NUM_SRC] = '{SRC_LOAD, SRC_SHIFT, SRC_TX, SRC_WB};

    // Field 0 of an instruction word is the destination, field k is source k-1.
    function automatic int inst_field_lsb(input int field, input int addr_w);
        return field * addr_w;
    endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple-dual-port block RAM: one write port, one read port with an optional
// output register (HIGH_PERFORMANCE) that is synchronously reset by rstb.
module sdp_bram #(
    parameter int    RAM_WIDTH       = 32,
    parameter int    RAM_DEPTH       = 256,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic                         clka,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         wea,
    input  logic                         clkb,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (wea) begin
            ram[addra] <= dina;
        end
    end

    // Read-first: a read and write to the same address on one edge returns old data.
    always_ff @(posedge clkb) begin
        if (enb) begin
            ram_data <= ram[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign doutb = ram_data;
        end else begin : g_high_perf
            logic [RAM_WIDTH-1:0] dout_reg;

            always_ff @(posedge clkb) begin
                if (rstb) begin
                    dout_reg <= '0;
                end else if (regceb) begin
                    dout_reg <= ram_data;
                end
            end

            assign doutb = dout_reg;
        end
    endgenerate

endmodule

// File: rtl/data_mem_mp.sv
// Multi-port PE data memory: prioritised load/shift/tx/write-back writes into
// NUM_RD BRAM replicas, one per read port. Optional macro DM_FWD_EN forwards
// a same-cycle commit into the read pipeline instead of returning old data.
module data_mem_mp
    import dm_pkg::*;
#(
    parameter int                DATA_W     = DM_DATA_W,
    parameter int                ADDR_W     = DM_ADDR_W,
    parameter int                NUM_RD     = DM_NUM_RD,
    parameter int                WB_DELAY   = DM_WB_DELAY,
    parameter logic [ADDR_W-1:0] BASE_SHIFT = ADDR_W'(DM_BASE_SHIFT),
    parameter logic [ADDR_W-1:0] BASE_WB    = ADDR_W'(DM_BASE_WB),
    parameter logic [ADDR_W-1:0] BASE_TX    = ADDR_W'(DM_BASE_TX)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_load,
    input  logic                         wr_shift,
    input  logic                         wr_tx,
    input  logic                         wr_wb,
    input  logic [DATA_W-1:0]            din,
    input  logic [DATA_W-1:0]            din_wb,
    input  logic                         rd_en,
    input  logic                         inst_v,
    input  logic [(NUM_RD+1)*ADDR_W-1:0] inst,
    input  logic                         shift_v,
    output logic [NUM_RD*DATA_W-1:0]     dout,
    output logic                         dout_v,
    output logic                         wr_drop
);

    localparam logic [ADDR_W-1:0] LOAD_LAST  = BASE_SHIFT - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SHIFT_LAST = BASE_WB - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TX_LAST    = '1;

    logic [ADDR_W-1:0] load_ptr;
    logic [ADDR_W-1:0] shift_ptr;
    logic [ADDR_W-1:0] tx_ptr;
    logic [ADDR_W-1:0] wb_pipe [WB_DELAY];
    logic [ADDR_W-1:0] raddr   [NUM_RD];

    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;

    logic              rd_v1;
    logic              rd_v2;

    logic [WR_NUM_SRC-1:0] req;
    logic [2:0]            req_cnt;
    wr_src_e               win_src;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_data;

    // Request vector ordered by priority rank so the scan can use WR_PRIO directly.
    assign req     = {wr_wb, wr_tx, wr_shift, wr_load};
    assign req_cnt = 3'(wr_load) + 3'(wr_shift) + 3'(wr_tx) + 3'(wr_wb);

    always_comb begin
        win_src  = SRC_NONE;
        win_addr = '0;
        win_data = din;
        for (int i = WR_NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_src = WR_PRIO[i];
            end
        end
        case (win_src)
            SRC_LOAD:  win_addr = load_ptr;
            SRC_SHIFT: win_addr = shift_ptr;
            SRC_TX:    win_addr = tx_ptr;
            SRC_WB: begin
                win_addr = wb_pipe[WB_DELAY-1];
                win_data = din_wb;
            end
            default:   win_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waddr   <= '0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            waddr   <= win_addr;
            wdata   <= win_data;
            wvalid  <= (win_src != SRC_NONE);
            wr_drop <= (req_cnt > 3'd1);
        end
    end

    // Each region pointer advances only when its own stream wins the write slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_ptr  <= '0;
            shift_ptr <= BASE_SHIFT;
            tx_ptr    <= BASE_TX;
        end else begin
            if (win_src == SRC_LOAD) begin
                load_ptr <= (load_ptr == LOAD_LAST) ? '0 : load_ptr + ADDR_W'(1);
            end
            if (win_src == SRC_SHIFT) begin
                shift_ptr <= (shift_ptr == SHIFT_LAST) ? BASE_SHIFT : shift_ptr + ADDR_W'(1);
            end
            if (win_src == SRC_TX) begin
                tx_ptr <= (tx_ptr == TX_LAST) ? BASE_TX : tx_ptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_DELAY; i++) begin
                wb_pipe[i] <= '0;
            end
        end else begin
            wb_pipe[0] <= inst_v ? inst[ADDR_W-1:0] : '0;
            for (int i = 1; i < WB_DELAY; i++) begin
                wb_pipe[i] <= wb_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_RD; k++) begin
                raddr[k] <= '0;
            end
        end else if (inst_v) begin
            for (int k = 0; k < NUM_RD; k++) begin
                raddr[k] <= inst[inst_field_lsb(k + 1, ADDR_W) +: ADDR_W];
            end
        end else if (shift_v) begin
            raddr[0] <= raddr[0] + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_v1 <= 1'b0;
            rd_v2 <= 1'b0;
        end else begin
            rd_v1 <= rd_en;
            rd_v2 <= rd_v1;
        end
    end

    assign dout_v = rd_v2;

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rep
            logic [DATA_W-1:0] ram_q;

            // A write stage caught by reset must not reach the array.
            sdp_bram #(
                .RAM_WIDTH       (DATA_W),
                .RAM_DEPTH       (1 << ADDR_W),
                .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
            ) u_bram (
                .clka   (clk),
                .addra  (waddr),
                .dina   (wdata),
                .wea    (wvalid & rst_n),
                .clkb   (clk),
                .addrb  (raddr[k]),
                .enb    (rd_en),
                .rstb   (!rst_n),
                .regceb (rd_v1),
                .doutb  (ram_q)
            );

`ifdef DM_FWD_EN
            logic              fwd_hit1;
            logic              fwd_hit2;
            logic [DATA_W-1:0] fwd_data1;
            logic [DATA_W-1:0] fwd_data2;

            // Follows the BRAM's two read stages so the override keeps latency 2.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    fwd_hit1  <= 1'b0;
                    fwd_hit2  <= 1'b0;
                    fwd_data1 <= '0;
                    fwd_data2 <= '0;
                end else begin
                    if (rd_en) begin
                        fwd_hit1  <= wvalid && (waddr == raddr[k]);
                        fwd_data1 <= wdata;
                    end
                    if (rd_v1) begin
                        fwd_hit2  <= fwd_hit1;
                        fwd_data2 <= fwd_data1;
                    end
                end
            end

            assign dout[k*DATA_W +: DATA_W] = fwd_hit2 ? fwd_data2 : ram_q;
`else
            assign dout[k*DATA_W +: DATA_W] = ram_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_mp.sv
// Directed and randomized checks of data_mem_mp against a cycle-level model
// built from the region, priority and latency rules of the memory.
module tb_data_mem_mp;

    localparam int DW      = 32;
    localparam int AW      = 8;
    localparam int NRD     = 2;
    localparam int WBD     = 4;
    localparam int DEPTH   = 256;
    localparam int B_SHIFT = 32;
    localparam int B_WB    = 64;
    localparam int B_TX    = 128;

    logic                    clk;
    logic                    rst_n;
    logic                    wr_load, wr_shift, wr_tx, wr_wb;
    logic [DW-1:0]           din, din_wb;
    logic                    rd_en;
    logic                    inst_v;
    logic [(NRD+1)*AW-1:0]   inst;
    logic                    shift_v;
    logic [NRD*DW-1:0]       dout;
    logic                    dout_v;
    logic                    wr_drop;

    int checks = 0;
    int errors = 0;

    data_mem_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_load  (wr_load),
        .wr_shift (wr_shift),
        .wr_tx    (wr_tx),
        .wr_wb    (wr_wb),
        .din      (din),
        .din_wb   (din_wb),
        .rd_en    (rd_en),
        .inst_v   (inst_v),
        .inst     (inst),
        .shift_v  (shift_v),
        .dout     (dout),
        .dout_v   (dout_v),
        .wr_drop  (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    int            m_load, m_shift, m_tx;
    int            m_raddr [NRD];
    int            wb_q [$];
    bit            m_pend_v;
    int            m_pend_a;
    logic [DW-1:0] m_pend_d;
    bit            m_s1_v;
    logic [DW-1:0] m_s1   [NRD];
    bit            m_s1_k [NRD];
    logic [DW-1:0] m_dout   [NRD];
    bit            m_dout_k [NRD];
    bit            m_dv, m_drop;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] port(input int k);
        return dout[k*DW +: DW];
    endfunction

    task automatic model_reset();
        m_load  = 0;
        m_shift = B_SHIFT;
        m_tx    = B_TX;
        for (int k = 0; k < NRD; k++) begin
            m_raddr[k]  = 0;
            m_dout[k]   = '0;
            m_dout_k[k] = 1'b1;
            m_s1_k[k]   = 1'b0;
        end
        wb_q.delete();
        for (int i = 0; i < WBD; i++) wb_q.push_back(0);
        m_pend_v = 1'b0;
        m_s1_v   = 1'b0;
        m_dv     = 1'b0;
        m_drop   = 1'b0;
    endtask

    task automatic idle();
        wr_load  = 1'b0;
        wr_shift = 1'b0;
        wr_tx    = 1'b0;
        wr_wb    = 1'b0;
        rd_en    = 1'b0;
        inst_v   = 1'b0;
        shift_v  = 1'b0;
    endtask

    // Advance one clock: update the model from the current inputs, then check outputs.
    task automatic tick();
        logic [DW-1:0] cap   [NRD];
        bit            cap_k [NRD];
        int            nreq;
        int            wb_tail;
        for (int k = 0; k < NRD; k++) begin
            cap[k]   = m_mem[m_raddr[k]];
            cap_k[k] = m_known[m_raddr[k]];
`ifdef DM_FWD_EN
            if (m_pend_v && m_pend_a == m_raddr[k]) begin
                cap[k]   = m_pend_d;
                cap_k[k] = 1'b1;
            end
`endif
        end
        nreq    = int'(wr_load) + int'(wr_shift) + int'(wr_tx) + int'(wr_wb);
        wb_tail = wb_q[WBD-1];
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_pend_v) begin
                m_mem[m_pend_a]   = m_pend_d;
                m_known[m_pend_a] = 1'b1;
            end
            if (m_s1_v) begin
                for (int k = 0; k < NRD; k++) begin
                    m_dout[k]   = m_s1[k];
                    m_dout_k[k] = m_s1_k[k];
                end
            end
            m_dv   = m_s1_v;
            m_s1_v = rd_en;
            if (rd_en) begin
                for (int k = 0; k < NRD; k++) begin
                    m_s1[k]   = cap[k];
                    m_s1_k[k] = cap_k[k];
                end
            end
            m_drop   = (nreq > 1);
            m_pend_v = (nreq > 0);
            m_pend_d = din;
            if (wr_load) begin
                m_pend_a = m_load;
                m_load   = (m_load + 1) % B_SHIFT;
            end else if (wr_shift) begin
                m_pend_a = m_shift;
                m_shift  = B_SHIFT + (m_shift - B_SHIFT + 1) % (B_WB - B_SHIFT);
            end else if (wr_tx) begin
                m_pend_a = m_tx;
                m_tx     = B_TX + (m_tx - B_TX + 1) % (DEPTH - B_TX);
            end else if (wr_wb) begin
                m_pend_a = wb_tail;
                m_pend_d = din_wb;
            end
            wb_q.push_front(inst_v ? int'(inst[AW-1:0]) : 0);
            void'(wb_q.pop_back());
            if (inst_v) begin
                for (int k = 0; k < NRD; k++) m_raddr[k] = int'(inst[(k+1)*AW +: AW]);
            end else if (shift_v) begin
                m_raddr[0] = (m_raddr[0] + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        chk("dout_v", {31'b0, dout_v}, {31'b0, m_dv});
        chk("wr_drop", {31'b0, wr_drop}, {31'b0, m_drop});
        for (int k = 0; k < NRD; k++) begin
            if (m_dout_k[k]) chk($sformatf("dout%0d", k), port(k), m_dout[k]);
        end
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        inst_v = 1'b1;
        inst   = {a1, a0, 8'h00};
        tick();
        inst_v = 1'b0;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();
        idle();
        din    = '0;
        din_wb = '0;
        inst   = '0;
        rst_n  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_dout_v", {31'b0, dout_v}, 32'd0);
        chk("rst_drop", {31'b0, wr_drop}, 32'd0);
        chk("rst_dout0", port(0), 32'd0);
        chk("rst_dout1", port(1), 32'd0);
        rst_n = 1'b1;

        // Three loads then read back 0 and 1
        wr_load = 1'b1;
        din = 32'hAAAA_0000; tick();
        din = 32'hBBBB_0001; tick();
        din = 32'hCCCC_0002; tick();
        wr_load = 1'b0;
        read2(8'h00, 8'h01);
        chk("load_p0", port(0), 32'hAAAA_0000);
        chk("load_p1", port(1), 32'hBBBB_0001);
        chk("load_v", {31'b0, dout_v}, 32'd1);
        tick();
        chk("hold_v", {31'b0, dout_v}, 32'd0);
        chk("hold_p0", port(0), 32'hAAAA_0000);
        read2(8'h02, 8'h02);
        chk("load_c", port(1), 32'hCCCC_0002);

        // Shift region wraps after 32 writes
        wr_shift = 1'b1;
        for (int i = 0; i < 33; i++) begin
            din = 32'h5000_0000 + i;
            tick();
        end
        wr_shift = 1'b0;
        read2(8'h20, 8'h21);
        chk("shift_wrap", port(0), 32'h5000_0020);
        chk("shift_2nd", port(1), 32'h5000_0001);
        read2(8'h3F, 8'h20);
        chk("shift_last", port(0), 32'h5000_001F);

        // Load and tx collide: load wins, tx dropped
        do_reset();
        wr_load = 1'b1;
        wr_tx   = 1'b1;
        din     = 32'h7777_0001;
        tick();
        chk("drop_pulse", {31'b0, wr_drop}, 32'd1);
        wr_load = 1'b0;
        din     = 32'h7777_0002;
        tick();
        chk("drop_clear", {31'b0, wr_drop}, 32'd0);
        wr_tx = 1'b0;
        read2(8'h00, 8'h80);
        chk("drop_load", port(0), 32'h7777_0001);
        chk("drop_tx", port(1), 32'h7777_0002);

        // Write-back lands at the delayed destination
        din_wb = 32'hD00D_0045;
        inst_v = 1'b1;
        inst   = {8'h00, 8'h00, 8'h45};
        tick();
        inst_v = 1'b0;
        for (int i = 0; i < WBD - 1; i++) tick();
        wr_wb = 1'b1;
        tick();
        wr_wb = 1'b0;
        read2(8'h45, 8'h45);
        chk("wb_p0", port(0), 32'hD00D_0045);
        chk("wb_p1", port(1), 32'hD00D_0045);

        // Read and commit to 8'h05 on the same edge
        wr_load = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din = 32'h6000_0000 + i;
            tick();
        end
        wr_load = 1'b0;
        din_wb = 32'hEEEE_0005;
        inst_v = 1'b1;
        inst   = {8'h05, 8'h05, 8'h05};
        tick();
        inst_v = 1'b0;
        for (int i = 0; i < WBD - 1; i++) tick();
        wr_wb = 1'b1;
        tick();
        wr_wb = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
`ifdef DM_FWD_EN
        chk("collide_fwd", port(0), 32'hEEEE_0005);
`else
        chk("collide_old", port(0), 32'h6000_0005);
`endif
        read2(8'h05, 8'h04);
        chk("collide_after", port(0), 32'hEEEE_0005);
        chk("load_4", port(1), 32'h6000_0004);

        // Reset while a write is pending and a read is issued
        do_reset();
        inst_v = 1'b1;
        inst   = '0;
        tick();
        inst_v  = 1'b0;
        wr_load = 1'b1;
        din     = 32'h2222_2222;
        tick();
        wr_load = 1'b0;
        rst_n   = 1'b0;
        rd_en   = 1'b1;
        tick();
        chk("rstw_v", {31'b0, dout_v}, 32'd0);
        chk("rstw_p0", port(0), 32'd0);
        rst_n = 1'b1;
        rd_en = 1'b0;
        tick();
        chk("rstw_squash", {31'b0, dout_v}, 32'd0);
        read2(8'h00, 8'h00);
        chk("rstw_nowrite", port(0), 32'h7777_0001);
        wr_load = 1'b1; din = 32'h3333_0000; tick(); wr_load = 1'b0;
        wr_shift = 1'b1; din = 32'h3333_0020; tick(); wr_shift = 1'b0;
        wr_tx = 1'b1; din = 32'h3333_0080; tick(); wr_tx = 1'b0;
        read2(8'h00, 8'h20);
        chk("base_load", port(0), 32'h3333_0000);
        chk("base_shift", port(1), 32'h3333_0020);
        read2(8'h80, 8'h80);
        chk("base_tx", port(0), 32'h3333_0080);

        // Randomized traffic against the model
        din_wb = 32'hCAFE_0000;
        for (int n = 0; n < 600; n++) begin
            rst_n    = ($urandom_range(0, 149) != 0);
            wr_load  = ($urandom_range(0, 3) == 0);
            wr_shift = ($urandom_range(0, 3) == 0);
            wr_tx    = ($urandom_range(0, 3) == 0);
            wr_wb    = ($urandom_range(0, 7) == 0);
            din      = $urandom;
            rd_en    = ($urandom_range(0, 1) == 1);
            inst_v   = ($urandom_range(0, 3) == 0);
            inst     = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 70)),
                        8'($urandom_range(0, 255))};
            shift_v  = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle();
        rst_n = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
